// File: rtl/add32_pkg.sv
// Shared constants, state encoding and sizing helper for the nibble-serial adder.
// Latency/backpressure: n/a (package only).
package add32_pkg;

  localparam int SLICE_W = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/nibble_serial_add32_cla4.sv
// 4-bit carry-lookahead adder slice, purely combinational.
// Latency: 0 cycles; no handshake.
module CLA_4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign s     = p ^ c[3:0];
  assign c_out = c[4];

endmodule

// File: rtl/nibble_serial_add32.sv
// WIDTH-bit adder computing one nibble per cycle through a single CLA_4; NIBBLE_SERIAL_SUB_EN adds a sub port.
// Latency: out_valid NIB cycles after accept; result held while out_ready is low, in_ready only in IDLE.
module nibble_serial_add32
  import add32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
`ifdef NIBBLE_SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int NIB   = WIDTH / SLICE_W;
  localparam int CNT_W = clog2(NIB);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NIB - 1);

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0]   b_eff;
  logic               carry_init;
  logic [SLICE_W-1:0] a_nib, b_nib, slice_s;
  logic               slice_c;

`ifdef NIBBLE_SERIAL_SUB_EN
  assign b_eff      = sub ? ~b : b;
  assign carry_init = sub | c_in;
`else
  assign b_eff      = b;
  assign carry_init = c_in;
`endif

  // Nibble base bit index is cnt*4, formed by appending two zero bits.
  assign a_nib = a_q[{cnt_q, 2'b00} +: SLICE_W];
  assign b_nib = b_q[{cnt_q, 2'b00} +: SLICE_W];

  CLA_4 u_slice (
    .a     (a_nib),
    .b     (b_nib),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_c)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    c_out_d = c_out_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_eff;
          carry_d = carry_init;
          s_d     = '0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        s_d[{cnt_q, 2'b00} +: SLICE_W] = slice_s;
        carry_d = slice_c;
        if (cnt_q == LAST) begin
          c_out_d = slice_c;
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (slice_s[SLICE_W-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      c_out_q <= c_out_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign s         = s_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add32.sv
// Directed and random checks of nibble_serial_add32 (WIDTH=32); SUB cases only with NIBBLE_SERIAL_SUB_EN.
module tb_nibble_serial_add32;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] s;
  logic        c_out;
  logic        ovf;
`ifdef NIBBLE_SERIAL_SUB_EN
  logic        sub;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  nibble_serial_add32 #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
`ifdef NIBBLE_SERIAL_SUB_EN
    .sub       (sub),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .c_out     (c_out),
    .ovf       (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_v, input logic tc);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    a = ta; b = tb_v; c_in = tc; in_valid = 1'b1;
    @(negedge clk);
    // Scramble operands after acceptance; the captured copy must be used.
    in_valid = 1'b0; a = $urandom; b = $urandom; c_in = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
`ifdef NIBBLE_SERIAL_SUB_EN
    sub = 1'b0;
`endif
    #12;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
    end
    n_checks++;
    if (s !== 32'h0 || c_out !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL reset_out: s=%h c_out=%b ovf=%b want 0/0/0", s, c_out, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic_add();
    int cyc;
    issue(32'h0000_0005, 32'h0000_0003, 1'b0);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 8) begin n_fail++; $display("FAIL basic_latency: got %0d want 8", cyc); end
    n_checks++;
    if (s !== 32'h0000_0008 || c_out !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL basic_sum: s=%h c=%b v=%b want 00000008/0/0", s, c_out, ovf);
    end
    release_out();
  endtask

  task automatic test_full_carry();
    int cyc;
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 8 || s !== 32'h0000_0000 || c_out !== 1'b1 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL ripple_all: cyc=%0d s=%h c=%b v=%b want 8/00000000/1/0", cyc, s, c_out, ovf);
    end
    release_out();
    issue(32'h0FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(cyc);
    n_checks++;
    if (s !== 32'h1000_0000 || c_out !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL ripple_top: s=%h c=%b v=%b want 10000000/0/0", s, c_out, ovf);
    end
    release_out();
    issue(32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    wait_done(cyc);
    n_checks++;
    if (s !== 32'hFFFF_FFFF || c_out !== 1'b0) begin
      n_fail++; $display("FAIL no_ripple: s=%h c=%b want ffffffff/0", s, c_out);
    end
    release_out();
  endtask

  task automatic test_overflow();
    int cyc;
    issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    wait_done(cyc);
    n_checks++;
    if (s !== 32'h8000_0000 || c_out !== 1'b0 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_pos: s=%h c=%b v=%b want 80000000/0/1", s, c_out, ovf);
    end
    release_out();
    issue(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_done(cyc);
    n_checks++;
    if (s !== 32'h0000_0000 || c_out !== 1'b1 || ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_neg: s=%h c=%b v=%b want 00000000/1/1", s, c_out, ovf);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int cyc;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL run_in_ready: got %b want 0", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    wait_done(cyc);
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || s !== 32'h2345_6789 || c_out !== 1'b0) begin
        n_fail++; $display("FAIL hold_%0d: out_valid=%b s=%h c=%b want 1/23456789/0", i, out_valid, s, c_out);
      end
      @(negedge clk);
    end
    release_out();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || s !== 32'h2345_6789) begin
      n_fail++; $display("FAIL release: out_valid=%b in_ready=%b s=%h want 0/1/23456789", out_valid, in_ready, s);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    issue(32'h1234_5678, 32'h1111_1111, 1'b0);
    repeat (3) @(negedge clk);
    n_checks++;
    if (s !== 32'h0000_0789 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL partial: s=%h out_valid=%b want 00000789/0", s, out_valid);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || s !== 32'h0 || in_ready !== 1'b1 || c_out !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: out_valid=%b s=%h in_ready=%b c=%b want 0/0/1/0", out_valid, s, in_ready, c_out);
    end
    @(negedge clk);
    rst = 1'b0;
    issue(32'h0000_0001, 32'h0000_0001, 1'b0);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 8 || s !== 32'h0000_0002 || c_out !== 1'b0) begin
      n_fail++; $display("FAIL after_reset: cyc=%0d s=%h c=%b want 8/00000002/0", cyc, s, c_out);
    end
    release_out();
  endtask

  task automatic test_random_sweep();
    int          cyc;
    logic [31:0] ra, rb;
    logic        rc, ev;
    logic [32:0] e;
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(1, 0));
      e  = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
      ev = (ra[31] == rb[31]) && (e[31] != ra[31]);
      issue(ra, rb, rc);
      wait_done(cyc);
      n_checks++;
      if ({c_out, s} !== e || ovf !== ev || cyc !== 8) begin
        n_fail++;
        $display("FAIL rand_%0d: a=%h b=%h ci=%b got c=%b s=%h v=%b cyc=%0d want c=%b s=%h v=%b cyc=8",
                 i, ra, rb, rc, c_out, s, ovf, cyc, e[32], e[31:0], ev);
      end
      release_out();
    end
  endtask

`ifdef NIBBLE_SERIAL_SUB_EN
  task automatic test_sub();
    int cyc;
    sub = 1'b1;
    issue(32'h0000_0005, 32'h0000_0007, 1'b0);
    sub = 1'b0;
    wait_done(cyc);
    n_checks++;
    if (s !== 32'hFFFF_FFFE || c_out !== 1'b0 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL sub_borrow: s=%h c=%b v=%b want fffffffe/0/0", s, c_out, ovf);
    end
    release_out();
    sub = 1'b1;
    issue(32'h0000_0007, 32'h0000_0005, 1'b0);
    sub = 1'b0;
    wait_done(cyc);
    n_checks++;
    if (s !== 32'h0000_0002 || c_out !== 1'b1 || ovf !== 1'b0) begin
      n_fail++; $display("FAIL sub_noborrow: s=%h c=%b v=%b want 00000002/1/0", s, c_out, ovf);
    end
    release_out();
  endtask
`endif

  initial begin
    test_reset();
    test_basic_add();
    test_full_carry();
    test_overflow();
    test_backpressure();
    test_reset_mid();
`ifdef NIBBLE_SERIAL_SUB_EN
    test_sub();
`endif
    test_random_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
